// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
// Hazard unit for a five-stage in-order pipeline (F/D/E/M/W):
//   * combinational operand forwarding into Execute (Memory and Writeback),
//   * load-use stall, taken-branch flush and data-memory wait stall,
//   * RUN/WAIT memory-wait FSM with a sticky timeout flag,
//   * optional saturating stall/flush performance counters.
//
// Build option:
//   HAZARD_PERF_CNT_EN  defined   -> StallCnt/FlushCnt counter registers exist
//                       undefined -> no counter registers, outputs tied to 0
//
// Wait-cycle accounting: the wait counter is cleared when the FSM enters WAIT
// and counts every completed cycle in WAIT. The timeout flag is loaded on the
// same edge that brings the counter to TIMEOUT, so it is visible from the
// (TIMEOUT+1)-th cycle spent in WAIT onward.
// -----------------------------------------------------------------------------
module hazard_ctrl #(
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       RS1_D,
   input  logic [4:0]       RS2_D,
   input  logic [4:0]       RS1_E,
   input  logic [4:0]       RS2_E,
   input  logic [4:0]       RD_E,
   input  logic             ResultSrcE,
   input  logic             PCSrcE,
   input  logic             RegWriteM,
   input  logic [4:0]       RD_M,
   input  logic             RegWriteW,
   input  logic [4:0]       RDW,
   input  logic             MemReadM,
   input  logic             MemReadyM,
   output logic [1:0]       ForwardAE,
   output logic [1:0]       ForwardBE,
   output logic             StallF,
   output logic             StallD,
   output logic             StallE,
   output logic             StallM,
   output logic             FlushD,
   output logic             FlushE,
   output logic             FlushW,
   output logic             MemTimeout,
   output logic [CNT_W-1:0] StallCnt,
   output logic [CNT_W-1:0] FlushCnt
);

   // Wait counter only needs to reach TIMEOUT; it saturates there.
   localparam int WCNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [WCNT_W-1:0] TIMEOUT_C = WCNT_W'(TIMEOUT);
   localparam logic [WCNT_W-1:0] WCNT_ONE  = WCNT_W'(1'b1);
   localparam logic [WCNT_W-1:0] WCNT_ZERO = WCNT_W'(1'b0);

   typedef enum logic [0:0] {
      ST_RUN  = 1'b0,
      ST_WAIT = 1'b1
   } state_e;

   state_e            state_q;
   state_e            state_d;
   logic [WCNT_W-1:0] wcnt_q;
   logic [WCNT_W-1:0] wcnt_d;
   logic              tmo_q;
   logic              tmo_d;

   logic              ld_miss_s;   // a load in Memory is not served this cycle
   logic              mw_s;        // memory-wait stall condition
   logic              lu_haz_s;    // load-use hazard between Execute and Decode

   // ---------------------------------------------------------------------
   // Forwarding select for one Execute source operand. Memory stage has the
   // youngest value and wins over Writeback; x0 is never forwarded.
   // ---------------------------------------------------------------------
   function automatic logic [1:0] fwd_sel(
      input logic [4:0] rs,
      input logic       wr_m,
      input logic [4:0] rd_m,
      input logic       wr_w,
      input logic [4:0] rd_w
   );
      logic [1:0] sel;
      if (wr_m && (rd_m != 5'd0) && (rd_m == rs)) begin
         sel = 2'b10;
      end else if (wr_w && (rd_w != 5'd0) && (rd_w == rs)) begin
         sel = 2'b01;
      end else begin
         sel = 2'b00;
      end
      return sel;
   endfunction

   // Operand forwarding muxes for both ALU sources (purely combinational).
   always_comb begin
      ForwardAE = fwd_sel(RS1_E, RegWriteM, RD_M, RegWriteW, RDW);
      ForwardBE = fwd_sel(RS2_E, RegWriteM, RD_M, RegWriteW, RDW);
   end

   // Hazard detection terms: memory wait and load-use.
   always_comb begin
      ld_miss_s = MemReadM & ~MemReadyM;
      mw_s      = ld_miss_s | ((state_q == ST_WAIT) & ~MemReadyM);
      lu_haz_s  = ResultSrcE & (RD_E != 5'd0) &
                  ((RD_E == RS1_D) | (RD_E == RS2_D));
   end

   // Stall/flush resolution with priority memory-wait > branch > load-use.
   always_comb begin
      StallF = 1'b0;
      StallD = 1'b0;
      StallE = 1'b0;
      StallM = 1'b0;
      FlushD = 1'b0;
      FlushE = 1'b0;
      FlushW = 1'b0;
      if (mw_s) begin
         // Freeze everything up to Memory; Writeback gets a bubble so the
         // stalled load is not retired twice.
         StallF = 1'b1;
         StallD = 1'b1;
         StallE = 1'b1;
         StallM = 1'b1;
         FlushW = 1'b1;
      end else if (PCSrcE) begin
         // Wrong-path instructions in Decode and Execute are squashed; a
         // pending load-use hazard is irrelevant because its consumer dies.
         FlushD = 1'b1;
         FlushE = 1'b1;
      end else if (lu_haz_s) begin
         // Hold the consumer in Decode and insert a bubble into Execute.
         StallF = 1'b1;
         StallD = 1'b1;
         FlushE = 1'b1;
      end else begin
         StallF = 1'b0;
         FlushE = 1'b0;
      end
   end

   // Memory-wait FSM next state, wait counter and sticky timeout flag.
   always_comb begin
      state_d = state_q;
      wcnt_d  = wcnt_q;
      tmo_d   = tmo_q;
      case (state_q)
         ST_RUN: begin
            if (ld_miss_s) begin
               state_d = ST_WAIT;
               wcnt_d  = WCNT_ZERO;
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_WAIT: begin
            if (MemReadyM) begin
               state_d = ST_RUN;
            end else begin
               // Stay in WAIT even after the timeout; the flag only reports.
               state_d = ST_WAIT;
               if (wcnt_q != TIMEOUT_C) begin
                  wcnt_d = wcnt_q + WCNT_ONE;
               end else begin
                  wcnt_d = wcnt_q;
               end
               if (wcnt_d == TIMEOUT_C) begin
                  tmo_d = 1'b1;
               end else begin
                  tmo_d = tmo_q;
               end
            end
         end
         default: begin
            state_d = ST_RUN;
            wcnt_d  = WCNT_ZERO;
         end
      endcase
   end

   // FSM, wait counter and timeout flag registers; reset is asynchronous so
   // the state-dependent stall drops as soon as rst goes low.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_RUN;
         wcnt_q  <= WCNT_ZERO;
         tmo_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         wcnt_q  <= wcnt_d;
         tmo_q   <= tmo_d;
      end
   end

   assign MemTimeout = tmo_q;

`ifdef HAZARD_PERF_CNT_EN
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

   logic [CNT_W-1:0] stall_cnt_q;
   logic [CNT_W-1:0] stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q;
   logic [CNT_W-1:0] flush_cnt_d;

   // Saturating counters: stalled fetch cycles and Execute bubbles.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (StallF && (stall_cnt_q != CNT_MAX)) begin
         stall_cnt_d = stall_cnt_q + CNT_ONE;
      end else begin
         stall_cnt_d = stall_cnt_q;
      end
      if (FlushE && (flush_cnt_q != CNT_MAX)) begin
         flush_cnt_d = flush_cnt_q + CNT_ONE;
      end else begin
         flush_cnt_d = flush_cnt_q;
      end
   end

   // Performance counter registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cnt_q <= CNT_ZERO;
         flush_cnt_q <= CNT_ZERO;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign StallCnt = stall_cnt_q;
   assign FlushCnt = flush_cnt_q;
`else
   assign StallCnt = {CNT_W{1'b0}};
   assign FlushCnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
// Self-checking bench for hazard_ctrl. A behavioural model tracks whether the
// pipeline is waiting on memory, how many cycles it has waited and the event
// totals; expected outputs are derived from the stall/flush priority rules.
// Inputs change on the falling edge, outputs are sampled 1 ns later, and the
// model advances on the rising edge.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;

   localparam int TIMEOUT = 16;
   localparam int CNT_W   = 32;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [4:0]       RS1_D, RS2_D, RS1_E, RS2_E, RD_E, RD_M, RDW;
   logic             ResultSrcE, PCSrcE, RegWriteM, RegWriteW, MemReadM, MemReadyM;
   logic [1:0]       ForwardAE, ForwardBE;
   logic             StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
   logic             MemTimeout;
   logic [CNT_W-1:0] StallCnt, FlushCnt;

   wire [6:0] ctl = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW};

   int n_checks;
   int n_errors;

   // behavioural model state
   bit         m_waiting;
   int         m_wait_cycles;
   bit         m_tmo;
   longint     m_scnt;
   longint     m_fcnt;
   logic [6:0] exp_ctl;
   logic [1:0] exp_fa, exp_fb;

   hazard_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst),
      .RS1_D(RS1_D), .RS2_D(RS2_D), .RS1_E(RS1_E), .RS2_E(RS2_E), .RD_E(RD_E),
      .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE),
      .RegWriteM(RegWriteM), .RD_M(RD_M), .RegWriteW(RegWriteW), .RDW(RDW),
      .MemReadM(MemReadM), .MemReadyM(MemReadyM),
      .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
      .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
      .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
      .MemTimeout(MemTimeout), .StallCnt(StallCnt), .FlushCnt(FlushCnt)
   );

   always #5 clk = ~clk;

   function automatic logic [1:0] fwd_ref(input logic [4:0] rs);
      if (RegWriteM && RD_M != 5'd0 && RD_M == rs) return 2'b10;
      if (RegWriteW && RDW != 5'd0 && RDW == rs) return 2'b01;
      return 2'b00;
   endfunction

   function automatic logic [CNT_W-1:0] exp_cnt(input longint v);
`ifdef HAZARD_PERF_CNT_EN
      return CNT_W'(v);
`else
      return {CNT_W{1'b0}};
`endif
   endfunction

   // expected outputs for the current inputs and model state
   function automatic void model_eval();
      bit mw, lu;
      mw = (MemReadM && !MemReadyM) || (m_waiting && !MemReadyM);
      lu = ResultSrcE && RD_E != 5'd0 && (RD_E == RS1_D || RD_E == RS2_D);
      if (mw)          exp_ctl = 7'b1111_001;
      else if (PCSrcE) exp_ctl = 7'b0000_110;
      else if (lu)     exp_ctl = 7'b1100_010;
      else             exp_ctl = 7'b0000_000;
      exp_fa = fwd_ref(RS1_E);
      exp_fb = fwd_ref(RS2_E);
   endfunction

   function automatic void model_reset();
      m_waiting = 1'b0; m_wait_cycles = 0; m_tmo = 1'b0; m_scnt = 0; m_fcnt = 0;
   endfunction

   function automatic void model_advance();
      longint cmax;
      cmax = (longint'(1) << CNT_W) - 1;
      if (!rst) begin
         model_reset();
         return;
      end
      model_eval();
      if (exp_ctl[6] && m_scnt < cmax) m_scnt++;
      if (exp_ctl[1] && m_fcnt < cmax) m_fcnt++;
      if (m_waiting) begin
         if (MemReadyM) m_waiting = 1'b0;
         else begin
            m_wait_cycles++;
            if (m_wait_cycles >= TIMEOUT) m_tmo = 1'b1;
         end
      end else if (MemReadM && !MemReadyM) begin
         m_waiting = 1'b1;
         m_wait_cycles = 0;
      end
   endfunction

   task automatic clear_inputs();
      RS1_D = 5'd0; RS2_D = 5'd0; RS1_E = 5'd0; RS2_E = 5'd0; RD_E = 5'd0;
      RD_M = 5'd0; RDW = 5'd0; ResultSrcE = 1'b0; PCSrcE = 1'b0;
      RegWriteM = 1'b0; RegWriteW = 1'b0; MemReadM = 1'b0; MemReadyM = 1'b1;
   endtask

   task automatic tick();
      @(posedge clk);
      model_advance();
   endtask

   task automatic test_reset();
      clear_inputs();
      #2 rst = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk); #1;
      n_checks++;
      if (ctl !== 7'b0) begin n_errors++; $display("FAIL reset_ctl: got %b exp %b", ctl, 7'b0); end
      n_checks++;
      if (MemTimeout !== 1'b0) begin n_errors++; $display("FAIL reset_tmo: got %b exp 0", MemTimeout); end
      n_checks++;
      if (StallCnt !== {CNT_W{1'b0}} || FlushCnt !== {CNT_W{1'b0}}) begin
         n_errors++; $display("FAIL reset_cnt: got %0d/%0d exp 0/0", StallCnt, FlushCnt);
      end
      @(negedge clk); rst = 1'b1;
      tick();
   endtask

   task automatic test_forward_directed();
      logic [1:0] ea, eb;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         clear_inputs();
         case (i)
            0: begin RegWriteM = 1'b1; RD_M = 5'd5; RS1_E = 5'd5; RS2_E = 5'd5;
                     RegWriteW = 1'b1; RDW = 5'd5; ea = 2'b10; eb = 2'b10; end
            1: begin RegWriteM = 1'b1; RD_M = 5'd0; RS1_E = 5'd0; RS2_E = 5'd0;
                     RegWriteW = 1'b1; RDW = 5'd5; ea = 2'b00; eb = 2'b00; end
            2: begin RegWriteM = 1'b0; RD_M = 5'd5; RS1_E = 5'd5; RS2_E = 5'd9;
                     RegWriteW = 1'b1; RDW = 5'd5; ea = 2'b01; eb = 2'b00; end
            3: begin RegWriteM = 1'b1; RD_M = 5'd9; RS1_E = 5'd3; RS2_E = 5'd9;
                     RegWriteW = 1'b1; RDW = 5'd3; ea = 2'b01; eb = 2'b10; end
            default: begin RegWriteM = 1'b1; RD_M = 5'd0; RS1_E = 5'd0; RS2_E = 5'd0;
                     RegWriteW = 1'b1; RDW = 5'd0; ea = 2'b00; eb = 2'b00; end
         endcase
         #1;
         n_checks++;
         if (ForwardAE !== ea || ForwardBE !== eb) begin
            n_errors++;
            $display("FAIL fwd_directed case %0d: got A=%b B=%b exp A=%b B=%b", i, ForwardAE, ForwardBE, ea, eb);
         end
         tick();
      end
   endtask

   task automatic test_load_use();
      logic [6:0] e;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         clear_inputs();
         case (i)
            0: begin ResultSrcE = 1'b1; RD_E = 5'd6; RS1_D = 5'd1; RS2_D = 5'd6; e = 7'b1100_010; end
            1: begin ResultSrcE = 1'b0; RD_E = 5'd6; RS1_D = 5'd1; RS2_D = 5'd6; e = 7'b0000_000; end
            2: begin ResultSrcE = 1'b1; RD_E = 5'd0; RS1_D = 5'd0; RS2_D = 5'd0; e = 7'b0000_000; end
            default: begin ResultSrcE = 1'b1; RD_E = 5'd7; RS1_D = 5'd7; RS2_D = 5'd2; e = 7'b1100_010; end
         endcase
         #1;
         n_checks++;
         if (ctl !== e) begin n_errors++; $display("FAIL load_use step %0d: got %b exp %b", i, ctl, e); end
         tick();
      end
   endtask

   task automatic test_branch_priority();
      logic [6:0] e;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         clear_inputs();
         case (i)
            0: begin PCSrcE = 1'b1; ResultSrcE = 1'b1; RD_E = 5'd6; RS2_D = 5'd6; e = 7'b0000_110; end
            1: begin PCSrcE = 1'b1; e = 7'b0000_110; end
            2: begin PCSrcE = 1'b1; MemReadM = 1'b1; MemReadyM = 1'b0; e = 7'b1111_001; end
            default: begin PCSrcE = 1'b1; MemReadyM = 1'b1; e = 7'b0000_110; end
         endcase
         #1;
         n_checks++;
         if (ctl !== e) begin n_errors++; $display("FAIL branch_prio step %0d: got %b exp %b", i, ctl, e); end
         tick();
      end
   endtask

   task automatic test_mem_wait();
      longint s0;
      logic [6:0] e;
      s0 = m_scnt;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         clear_inputs();
         MemReadM  = (i < 4) ? 1'b1 : 1'b0;
         MemReadyM = (i == 3) ? 1'b1 : 1'b0;
         e = (i < 3) ? 7'b1111_001 : 7'b0000_000;
         #1;
         n_checks++;
         if (ctl !== e) begin n_errors++; $display("FAIL mem_wait cycle %0d: got %b exp %b", i, ctl, e); end
         if (i == 4) begin
            n_checks++;
            if (StallCnt !== exp_cnt(s0 + 3)) begin
               n_errors++; $display("FAIL mem_wait_cnt: got %0d exp %0d", StallCnt, exp_cnt(s0 + 3));
            end
         end
         tick();
      end
   endtask

   task automatic test_timeout();
      logic etmo;
      // 20 cycles with MemReadyM low: first one in RUN, then 19 in WAIT
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         clear_inputs();
         MemReadM  = (k == 1) ? 1'b1 : 1'b0;
         MemReadyM = 1'b0;
         #1;
         etmo = (k - 1 >= TIMEOUT + 1) ? 1'b1 : 1'b0;  // from 17th cycle in WAIT
         n_checks++;
         if (MemTimeout !== etmo || ctl !== 7'b1111_001) begin
            n_errors++;
            $display("FAIL timeout cycle %0d: got tmo=%b ctl=%b exp tmo=%b ctl=%b", k, MemTimeout, ctl, etmo, 7'b1111_001);
         end
         tick();
      end
      // asynchronous reset in the middle of WAIT
      @(negedge clk); #3;
      rst = 1'b0;
      #1;
      n_checks++;
      if (ctl !== 7'b0 || MemTimeout !== 1'b0) begin
         n_errors++; $display("FAIL async_reset: got ctl=%b tmo=%b exp ctl=%b tmo=0", ctl, MemTimeout, 7'b0);
      end
      n_checks++;
      if (StallCnt !== {CNT_W{1'b0}} || FlushCnt !== {CNT_W{1'b0}}) begin
         n_errors++; $display("FAIL async_reset_cnt: got %0d/%0d exp 0/0", StallCnt, FlushCnt);
      end
      tick();
      @(negedge clk); rst = 1'b1;
      #1;
      n_checks++;
      if (ctl !== 7'b0) begin n_errors++; $display("FAIL after_reset_run: got %b exp %b", ctl, 7'b0); end
      tick();
   endtask

   task automatic test_back_to_back();
      logic [6:0] e;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         clear_inputs();
         MemReadM = 1'b1;
         case (i)
            0: begin MemReadyM = 1'b0; e = 7'b1111_001; end
            1: begin MemReadyM = 1'b1; e = 7'b0000_000; end
            2: begin MemReadyM = 1'b0; e = 7'b1111_001; end
            3: begin MemReadyM = 1'b1; ResultSrcE = 1'b1; RD_E = 5'd4; RS1_D = 5'd4; e = 7'b1100_010; end
            default: begin MemReadyM = 1'b1; e = 7'b0000_000; end
         endcase
         #1;
         n_checks++;
         if (ctl !== e) begin n_errors++; $display("FAIL back_to_back step %0d: got %b exp %b", i, ctl, e); end
         tick();
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         RS1_D = 5'($urandom_range(0, 3)); RS2_D = 5'($urandom_range(0, 3));
         RS1_E = 5'($urandom_range(0, 3)); RS2_E = 5'($urandom_range(0, 3));
         RD_E  = 5'($urandom_range(0, 3)); RD_M  = 5'($urandom_range(0, 3));
         RDW   = 5'($urandom_range(0, 3));
         ResultSrcE = 1'($urandom); PCSrcE = ($urandom_range(0, 3) == 0);
         RegWriteM = 1'($urandom); RegWriteW = 1'($urandom);
         MemReadM = 1'($urandom); MemReadyM = ($urandom_range(0, 2) != 0);
         #1;
         model_eval();
         n_checks++;
         if (ctl !== exp_ctl) begin n_errors++; $display("FAIL random_ctl cyc %0d: got %b exp %b", i, ctl, exp_ctl); end
         n_checks++;
         if (ForwardAE !== exp_fa || ForwardBE !== exp_fb) begin
            n_errors++; $display("FAIL random_fwd cyc %0d: got %b/%b exp %b/%b", i, ForwardAE, ForwardBE, exp_fa, exp_fb);
         end
         n_checks++;
         if (MemTimeout !== m_tmo || StallCnt !== exp_cnt(m_scnt) || FlushCnt !== exp_cnt(m_fcnt)) begin
            n_errors++;
            $display("FAIL random_state cyc %0d: got tmo=%b sc=%0d fc=%0d exp tmo=%b sc=%0d fc=%0d",
                     i, MemTimeout, StallCnt, FlushCnt, m_tmo, exp_cnt(m_scnt), exp_cnt(m_fcnt));
         end
         tick();
      end
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      clear_inputs();
      model_reset();
      test_reset();
      test_forward_directed();
      test_load_use();
      test_branch_priority();
      test_mem_wait();
      test_timeout();
      test_back_to_back();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
